// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier host adapter.
// Operand width and FSM state encoding live here.
package booth_pkg;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(256);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_WAIT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/booth_host_if_if.sv
// Host-side valid/ready ports of the Booth adapter.
// The master side supplies operands and consumes products.
interface booth_host_if_if;
  import booth_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prod;
  logic          out_err;

  modport master (
    output in_valid,
    output in_x,
    output in_y,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_prod,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_prod,
    output out_err
  );

endinterface

// File: rtl/booth_timeout_ctr.sv
// Saturating cycle counter that flags the last cycle
// before a programmable limit is reached.
module booth_timeout_ctr
  import booth_pkg::*;
(
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == (limit - 1'b1));

endmodule

// File: rtl/booth_host_if.sv
// Host adapter for the serial Booth core: feeds operands on
// bgn/ibus, captures the two obus product bytes, returns them.
module booth_host_if
  import booth_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_b,
  booth_host_if_if.slave h,
  output logic           bgn,
  output logic [W-1:0]   ibus,
  input  logic [W-1:0]   obus,
  input  logic           stop
);

  state_t        st;
  state_t        nx;
  logic [W-1:0]  y_q;
  logic [W-1:0]  obus_q;
  logic          stop_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [PW-1:0] prod_q;
  logic          err_q;
  logic          acc;
  logic          rise;
  logic          expired;

  assign acc  = h.in_valid & in_ready_q;
  assign rise = stop & ~stop_q;

  assign h.in_ready  = in_ready_q;
  assign h.out_valid = out_valid_q;
  assign h.out_prod  = prod_q;
  assign h.out_err   = err_q;

  booth_timeout_ctr u_to (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (st == S_LOAD_Y),
    .en      (st == S_WAIT),
    .limit   (CW'(TIMEOUT)),
    .expired (expired)
  );

  always_comb begin
    nx = st;
    unique case (st)
      S_IDLE:   if (acc) nx = S_LOAD_X;
      S_LOAD_X: nx = S_LOAD_Y;
      S_LOAD_Y: nx = S_WAIT;
      S_WAIT:   if (rise || expired) nx = S_HOLD;
      S_HOLD:   if (h.out_ready) nx = S_IDLE;
      default:  nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st          <= S_IDLE;
      y_q         <= '0;
      obus_q      <= '0;
      stop_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      bgn         <= 1'b0;
      ibus        <= '0;
    end else begin
      st          <= nx;
      in_ready_q  <= (nx == S_IDLE);
      out_valid_q <= (nx == S_HOLD);
      bgn         <= (nx == S_LOAD_X);
      if (st == S_IDLE && acc) begin
        y_q <= h.in_y;
      end
      unique case (1'b1)
        (nx == S_LOAD_X): ibus <= h.in_x;
        (nx == S_LOAD_Y): ibus <= y_q;
        default:          ibus <= '0;
      endcase
      // Preloaded high: a stop that is already high on entry
      // is stale, only a low-then-high seen in WAIT counts.
      if (st == S_LOAD_Y) begin
        stop_q <= 1'b1;
        obus_q <= '0;
      end else if (st == S_WAIT) begin
        stop_q <= stop;
        obus_q <= obus;
      end
      if (st == S_WAIT) begin
        if (rise) begin
          prod_q <= {obus_q, obus};
          err_q  <= 1'b0;
        end else if (expired) begin
          prod_q <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_host_if.sv
// Bench for booth_host_if with a behavioural Booth core
// and a directly driven stub core for fault cases.
module tb_booth_host_if;
  import booth_pkg::*;

  localparam int TO   = 64;
  localparam int CLAT = 10;

  logic         clk;
  logic         rst_b;
  logic         bgn;
  logic [W-1:0] ibus;
  logic [W-1:0] obus;
  logic         stop;

  booth_host_if_if hif ();

  booth_host_if #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .h     (hif),
    .bgn   (bgn),
    .ibus  (ibus),
    .obus  (obus),
    .stop  (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core model: load x, load y, 8 compute cycles, hi, lo+stop
  logic               stub_mode;
  logic [W-1:0]       s_obus;
  logic               s_stop;
  logic [W-1:0]       c_obus;
  logic               c_stop;
  logic signed [7:0]  cx;
  logic signed [7:0]  cy;
  logic signed [15:0] cp;
  int                 cs;
  int                 cn;

  assign cp   = cx * cy;
  assign obus = stub_mode ? s_obus : c_obus;
  assign stop = stub_mode ? s_stop : c_stop;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cs     <= 0;
      cn     <= 0;
      cx     <= '0;
      cy     <= '0;
      c_obus <= '0;
      c_stop <= 1'b0;
    end else begin
      case (cs)
        0: if (bgn) begin
          cx     <= ibus;
          c_stop <= 1'b0;
          c_obus <= '0;
          cs     <= 1;
        end
        1: begin
          cy <= ibus;
          cn <= 0;
          cs <= 2;
        end
        2: begin
          cn <= cn + 1;
          if (cn == 7) begin
            c_obus <= cp[15:8];
            cs     <= 3;
          end
        end
        default: begin
          c_obus <= cp[7:0];
          c_stop <= 1'b1;
          cs     <= 0;
        end
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // accept a pair and follow it into WAIT
  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    while (!hif.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready", hif.in_ready, 1);
    hif.in_valid = 1'b1;
    hif.in_x     = x;
    hif.in_y     = y;
    tick();
    hif.in_valid = 1'b0;
    hif.in_x     = 8'($urandom);
    hif.in_y     = 8'($urandom);
    chk("bgn_x", bgn, 1);
    chk("ibus_x", ibus, x);
    chk("busy", hif.in_ready, 0);
    tick();
    chk("bgn_y", bgn, 0);
    chk("ibus_y", ibus, y);
    tick();
  endtask

  task automatic wait_out(input int elat,
                          input logic [15:0] ep,
                          input logic ee);
    int n;
    n = 0;
    while (!hif.out_valid && n < 300) begin
      tick();
      n++;
    end
    chk("latency", n, elat);
    chk("prod", hif.out_prod, ep);
    chk("err", hif.out_err, ee);
  endtask

  task automatic drain(input int rdly,
                       input logic [15:0] ep,
                       input logic ee);
    repeat (rdly) begin
      tick();
      chk("hold_v", hif.out_valid, 1);
      chk("hold_p", hif.out_prod, ep);
      chk("hold_e", hif.out_err, ee);
    end
    hif.out_ready = 1'b1;
    tick();
    hif.out_ready = 1'b0;
    chk("v_drop", hif.out_valid, 0);
    chk("rdy_back", hif.in_ready, 1);
  endtask

  task automatic run_pair(input logic [7:0] x,
                          input logic [7:0] y,
                          input int rdly);
    logic [15:0] ep;
    ep = ref_mul(x, y);
    send(x, y);
    wait_out(CLAT, ep, 1'b0);
    drain(rdly, ep, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", hif.in_ready, 0);
    chk("rst_bgn", bgn, 0);
    chk("rst_ibus", ibus, 0);
    chk("rst_valid", hif.out_valid, 0);
    chk("rst_prod", hif.out_prod, 0);
    chk("rst_err", hif.out_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_b         = 1'b0;
    stub_mode     = 1'b0;
    s_obus        = '0;
    s_stop        = 1'b0;
    hif.in_valid  = 1'b0;
    hif.in_x      = '0;
    hif.in_y      = '0;
    hif.out_ready = 1'b0;
    repeat (3) tick();
    chk_reset_vals();
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("idle_ready", hif.in_ready, 1);

    run_pair(8'd2, 8'd3, 0);
    run_pair(8'hFE, 8'h03, 0);
    run_pair(8'h80, 8'h80, 1);
    run_pair(8'h7F, 8'h81, 10);

    repeat (20) begin
      run_pair(8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    // stop never rises
    stub_mode = 1'b1;
    s_stop    = 1'b0;
    s_obus    = 8'h5A;
    send(8'd9, 8'd9);
    wait_out(TO, 16'h0000, 1'b1);
    drain(2, 16'h0000, 1'b1);

    // reset while the core is computing
    stub_mode = 1'b0;
    send(8'd11, 8'd13);
    repeat (3) tick();
    rst_b = 1'b0;
    #2;
    chk_reset_vals();
    @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (hif.out_valid) seen++;
    end
    chk("no_ovalid", seen, 0);
    run_pair(8'd5, 8'd7, 0);

    // stale stop left high by the core
    stub_mode = 1'b1;
    s_stop    = 1'b1;
    s_obus    = 8'hEE;
    send(8'd4, 8'd4);
    repeat (5) begin
      chk("stale", hif.out_valid, 0);
      tick();
    end
    s_stop = 1'b0;
    s_obus = 8'h12;
    tick();
    s_stop = 1'b1;
    s_obus = 8'h34;
    tick();
    chk("stub_v", hif.out_valid, 1);
    chk("stub_p", hif.out_prod, 16'h1234);
    chk("stub_e", hif.out_err, 0);
    drain(0, 16'h1234, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
